debounce_multi: RTL and testbench

Multi-channel input conditioner: each of `Count` asynchronous inputs (buttons, switches, external strobes) passes through a synchroniser and a stable-period filter. The block then emits a clean level, one-cycle rise/fall pulses and an optional long-press indication. It is the parametrised successor to the plain `debouncer`, adding a configurable synchroniser depth, reset, edge pulses and hold detection, and it sits between board I/O pins and the CPU's MMIO/GPIO logic.

---
 rtl/debounce_multi.sv | 109 ++++++++++
 tb/tb_debounce_multi.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel input conditioner: per-channel synchroniser, stable-period filter,
// registered rise/fall pulses and optional long-press (hold) detection.
module debounce_multi #(
   parameter int unsigned Count      = 1,
   parameter int unsigned Period     = 10,
   parameter int unsigned SyncStages = 2,
   parameter logic        ResetValue = 1'b0,
   parameter int unsigned HoldPeriod = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [Count-1:0] sig_i,
   output logic [Count-1:0] sig_o,
   output logic [Count-1:0] rise_o,
   output logic [Count-1:0] fall_o,
   output logic [Count-1:0] held_o
);

   localparam int unsigned       CntW   = $clog2(Period + 1);
   localparam logic [CntW-1:0]   CntMax = CntW'(Period - 1);

   for (genvar g = 0; g < Count; g++) begin : g_ch
      logic [SyncStages-1:0] r_sync;
      logic [CntW-1:0]       r_cnt;
      logic [CntW-1:0]       w_cnt_d;
      logic                  r_sig;
      logic                  r_rise;
      logic                  r_fall;
      logic                  w_sig_d;
      logic                  w_rise_d;
      logic                  w_fall_d;
      logic                  w_s;

      assign w_s = r_sync[SyncStages-1];

      // Any sample agreeing with the output restarts the count from zero.
      always_comb begin
         w_cnt_d  = '0;
         w_sig_d  = r_sig;
         w_rise_d = 1'b0;
         w_fall_d = 1'b0;
         if (w_s != r_sig) begin
            if (r_cnt == CntMax) begin
               w_sig_d  = w_s;
               w_rise_d = w_s;
               w_fall_d = ~w_s;
            end else begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_sync <= {SyncStages{ResetValue}};
            r_cnt  <= '0;
            r_sig  <= ResetValue;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
         end else begin
            r_sync <= {r_sync[SyncStages-2:0], sig_i[g]};
            r_cnt  <= w_cnt_d;
            r_sig  <= w_sig_d;
            r_rise <= w_rise_d;
            r_fall <= w_fall_d;
         end
      end

      assign sig_o[g]  = r_sig;
      assign rise_o[g] = r_rise;
      assign fall_o[g] = r_fall;

      if (HoldPeriod > 0) begin : g_hold
         localparam int unsigned      HoldW   = $clog2(HoldPeriod + 1);
         localparam logic [HoldW-1:0] HoldMax = HoldW'(HoldPeriod);

         logic [HoldW-1:0] r_hcnt;
         logic [HoldW-1:0] w_hcnt_d;
         logic             r_held;
         logic             w_held_d;

         // Built from next-state values so held drops on the same edge sig falls.
         always_comb begin
            w_hcnt_d = r_hcnt;
            if (!w_sig_d || w_rise_d) begin
               w_hcnt_d = '0;
            end else if (r_hcnt != HoldMax) begin
               w_hcnt_d = r_hcnt + 1'b1;
            end
            w_held_d = w_sig_d && (w_hcnt_d == HoldMax);
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               r_hcnt <= '0;
               r_held <= 1'b0;
            end else begin
               r_hcnt <= w_hcnt_d;
               r_held <= w_held_d;
            end
         end

         assign held_o[g] = r_held;
      end else begin : g_no_hold
         assign held_o[g] = 1'b0;
      end
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Randomised bench for debounce_multi: a window-based reference model (last Period
// synchronised samples all disagree with the output) predicts every output each cycle.
module tb_debounce_multi;

   localparam int unsigned Count      = 2;
   localparam int unsigned Period     = 10;
   localparam int unsigned SyncStages = 2;
   localparam logic        ResetValue = 1'b0;
   localparam int unsigned HoldPeriod = 30;
   localparam int          MaxEdges   = 4096;

   logic             clk;
   logic             rst;
   logic [Count-1:0] sig_i;
   logic [Count-1:0] sig_o;
   logic [Count-1:0] rise_o;
   logic [Count-1:0] fall_o;
   logic [Count-1:0] held_o;

   debounce_multi #(
      .Count      (Count),
      .Period     (Period),
      .SyncStages (SyncStages),
      .ResetValue (ResetValue),
      .HoldPeriod (HoldPeriod)
   ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (sig_i),
      .sig_o  (sig_o),
      .rise_o (rise_o),
      .fall_o (fall_o),
      .held_o (held_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (time %0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model state: per-edge history of inputs and reset.
   logic [Count-1:0] hist_sig [MaxEdges];
   bit               hist_rst [MaxEdges];
   int               k = -1;
   logic [Count-1:0] m_sig;
   int               m_rise_edge [Count];

   // Synchronised sample seen by the filter at edge j.
   function automatic logic s_of(input int j, input int ch);
      if (j - int'(SyncStages) < 0) return ResetValue;
      for (int m = 1; m <= int'(SyncStages); m++) begin
         if (hist_rst[j-m]) return ResetValue;
      end
      return hist_sig[j-int'(SyncStages)][ch];
   endfunction

   task automatic step(input logic [Count-1:0] s, input bit r);
      logic [Count-1:0] e_rise;
      logic [Count-1:0] e_fall;
      logic [Count-1:0] e_held;
      bit               ok;
      sig_i = s;
      rst   = r;
      @(posedge clk);
      k++;
      if (k >= MaxEdges) begin
         $display("FAIL edge_budget: got %0d edges, expected < %0d", k, MaxEdges);
         $fatal(1);
      end
      hist_sig[k] = s;
      hist_rst[k] = r;
      e_rise = '0;
      e_fall = '0;
      e_held = '0;
      if (r) begin
         m_sig = {Count{ResetValue}};
      end else begin
         for (int ch = 0; ch < int'(Count); ch++) begin
            ok = (k >= int'(Period) - 1);
            for (int j = k - int'(Period) + 1; ok && j <= k; j++) begin
               if (hist_rst[j] || s_of(j, ch) == m_sig[ch]) ok = 1'b0;
            end
            if (ok) begin
               m_sig[ch]  = ~m_sig[ch];
               e_rise[ch] = m_sig[ch];
               e_fall[ch] = ~m_sig[ch];
               if (m_sig[ch]) m_rise_edge[ch] = k;
            end
            e_held[ch] = m_sig[ch] && (k - m_rise_edge[ch] >= int'(HoldPeriod));
         end
      end
      #1;
      check("sig_o", 32'(sig_o), 32'(m_sig));
      check("rise_o", 32'(rise_o), 32'(e_rise));
      check("fall_o", 32'(fall_o), 32'(e_fall));
      check("held_o", 32'(held_o), 32'(e_held));
      check("rise_fall_excl", 32'(rise_o & fall_o), 32'd0);
      @(negedge clk);
   endtask

   task automatic run(input logic [Count-1:0] s, input bit r, input int n);
      for (int i = 0; i < n; i++) step(s, r);
   endtask

   int               rel_edge;
   int               lat;
   int               remain [Count];
   logic [Count-1:0] rnd_sig;

   initial begin
      sig_i = '1;
      rst   = 1'b1;
      m_sig = {Count{ResetValue}};
      for (int ch = 0; ch < int'(Count); ch++) m_rise_edge[ch] = 0;
      @(negedge clk);

      // Reset with inputs high: all outputs low.
      run(2'b11, 1'b1, 2);
      check("reset_outputs", 32'({sig_o, rise_o, fall_o, held_o}), 32'd0);

      // Release with inputs still high; measure latency to the rise.
      lat      = -1;
      rel_edge = k + 1;
      for (int i = 0; i < 15; i++) begin
         step(2'b11, 1'b0);
         if (lat < 0 && sig_o == 2'b11) lat = k - rel_edge;
      end
      check("release_latency", 32'(lat), 32'd11);

      // Simultaneous fall, clean step on ch0, glitch and short pulse on ch1.
      run(2'b00, 1'b0, 20);
      run(2'b01, 1'b0, 20);
      run(2'b11, 1'b0, 9);
      run(2'b01, 1'b0, 1);
      run(2'b11, 1'b0, 10);
      run(2'b01, 1'b0, 15);
      run(2'b00, 1'b0, 20);
      run(2'b10, 1'b0, 5);
      run(2'b00, 1'b0, 20);

      // Long press on ch0 then release.
      run(2'b01, 1'b0, 50);
      check("held_after_long_press", 32'(held_o), 32'd1);
      run(2'b00, 1'b0, 20);

      // Reset mid-count discards progress.
      run(2'b01, 1'b0, 7);
      run(2'b01, 1'b1, 1);
      run(2'b01, 1'b0, 15);
      run(2'b00, 1'b0, 15);

      // Random level runs, mixing glitches, steps, long presses and rare resets.
      for (int ch = 0; ch < int'(Count); ch++) remain[ch] = 0;
      rnd_sig = '0;
      for (int i = 0; i < 2500; i++) begin
         for (int ch = 0; ch < int'(Count); ch++) begin
            if (remain[ch] == 0) begin
               rnd_sig[ch] = 1'($urandom_range(1, 0));
               remain[ch]  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(12, 1))
                                                          : int'($urandom_range(45, 13));
            end
            remain[ch]--;
         end
         step(rnd_sig, ($urandom_range(299, 0) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
